// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared constants and types for the data-memory / MMIO stage.
// Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    localparam logic [4:0] OFF_GPIO   = 5'h00;
    localparam logic [4:0] OFF_CYCLE  = 5'h04;
    localparam logic [4:0] OFF_STORES = 5'h08;
    localparam logic [4:0] OFF_TIMER  = 5'h0C;
    localparam logic [4:0] OFF_STATUS = 5'h10;

    localparam int STAT_EXPIRED  = 0;
    localparam int STAT_MISALIGN = 1;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_MMIO = 2'd1,
        REG_NONE = 2'd2
    } region_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_timer.sv
`default_nettype none
// ============================================================================
// Module      : dmem_timer
// Description : Loadable 32-bit down-counter that stops at zero and flags the
//               1->0 transition with a single-cycle expire pulse.
// Revision    : 1.0  initial release
// ============================================================================
module dmem_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_load_val,
    output logic [31:0] o_value,
    output logic        o_expire
);

    logic [31:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != 32'd0) begin
            r_count <= r_count - 32'd1;
        end
    end

    assign o_value  = r_count;
    // A load in the same cycle overrides the decrement, so no expiry then.
    assign o_expire = !i_load && (r_count == 32'd1);

endmodule : dmem_timer
`default_nettype wire

// File: rtl/data_mem_mmio.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_mmio
// Description : Word RAM plus memory-mapped GPIO, cycle/store counters,
//               optional down-timer (macro DMEM_TIMER_EN) and status register.
// Revision    : 1.0  initial release
// ============================================================================
module data_mem_mmio
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [15:0] GPIO_OUT,
    output logic        TIMER_IRQ
);

    localparam int unsigned c_aw        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_ram_bytes = 32'(DEPTH_WORDS * 4);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [15:0] r_gpio;
    logic [31:0] r_cycle;
    logic [31:0] r_stores;
    logic        r_err;

    region_t          w_region;
    logic [31:0]      w_mmio_rel;
    logic [c_aw-1:0]  w_ram_idx;
    logic [4:0]       w_off;
    logic [4:0]       w_rd_off;
    logic             w_aligned;
    logic             w_ram_wr;
    logic             w_mmio_wr;
    logic             w_status_wr;
    logic [31:0]      w_timer_val;
    logic             w_expired;
    logic             w_expire;

    // Relative compare keeps the window check safe near the top of the map.
    always_comb begin
        w_mmio_rel = ALUResult - MMIO_BASE;
        if (ALUResult < c_ram_bytes) begin
            w_region = REG_RAM;
        end else if ((ALUResult >= MMIO_BASE) && (w_mmio_rel < 32'd32)) begin
            w_region = REG_MMIO;
        end else begin
            w_region = REG_NONE;
        end
    end

    assign w_ram_idx   = ALUResult[c_aw+1:2];
    assign w_off       = ALUResult[4:0];
    assign w_rd_off    = {ALUResult[4:2], 2'b00};
    assign w_aligned   = (ALUResult[1:0] == 2'b00);
    assign w_ram_wr    = MemWrite && w_aligned && (w_region == REG_RAM);
    assign w_mmio_wr   = MemWrite && w_aligned && (w_region == REG_MMIO);
    assign w_status_wr = w_mmio_wr && (w_off == OFF_STATUS);

    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_ram_wr) begin
            r_mem[w_ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_gpio   <= '0;
            r_cycle  <= '0;
            r_stores <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_mmio_wr && (w_off == OFF_GPIO)) begin
                r_gpio <= WriteData[15:0];
            end
            if (w_ram_wr && (r_stores != 32'hFFFF_FFFF)) begin
                r_stores <= r_stores + 32'd1;
            end
        end
    end

    // Set beats write-1-to-clear; misaligned stores fault regardless of target.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (MemWrite && !w_aligned) begin
            r_err <= 1'b1;
        end else if (w_status_wr && WriteData[STAT_MISALIGN]) begin
            r_err <= 1'b0;
        end
    end

`ifdef DMEM_TIMER_EN
    logic w_timer_wr;
    logic r_expired;

    assign w_timer_wr = w_mmio_wr && (w_off == OFF_TIMER);

    dmem_timer u_timer (
        .clk        (CLK),
        .rst        (rst),
        .i_load     (w_timer_wr),
        .i_load_val (WriteData),
        .o_value    (w_timer_val),
        .o_expire   (w_expire)
    );

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_expired <= 1'b0;
        end else if (w_expire) begin
            r_expired <= 1'b1;
        end else if (w_status_wr && WriteData[STAT_EXPIRED]) begin
            r_expired <= 1'b0;
        end
    end

    assign w_expired = r_expired;
`else
    assign w_timer_val = '0;
    assign w_expire    = 1'b0;
    assign w_expired   = 1'b0;
`endif

    always_comb begin
        ReadData = '0;
        case (w_region)
            REG_RAM: ReadData = r_mem[w_ram_idx];
            REG_MMIO: begin
                case (w_rd_off)
                    OFF_GPIO:   ReadData = {16'h0000, r_gpio};
                    OFF_CYCLE:  ReadData = r_cycle;
                    OFF_STORES: ReadData = r_stores;
                    OFF_TIMER:  ReadData = w_timer_val;
                    OFF_STATUS: ReadData = {30'h0, r_err, w_expired};
                    default:    ReadData = '0;
                endcase
            end
            default: ReadData = '0;
        endcase
    end

    assign GPIO_OUT  = r_gpio;
    assign TIMER_IRQ = w_expired;

endmodule : data_mem_mmio
`default_nettype wire

// File: tb/tb_data_mem_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_mmio
// Description : Directed self-checking bench for data_mem_mmio.
// Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_mmio;

    localparam logic [31:0] c_mmio = 32'hFFFF_0000;

    logic        CLK;
    logic        rst;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [15:0] GPIO_OUT;
    logic        TIMER_IRQ;

    int n_total = 0;
    int n_bad   = 0;

    data_mem_mmio #(
        .DEPTH_WORDS (64),
        .MMIO_BASE   (c_mmio)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .GPIO_OUT  (GPIO_OUT),
        .TIMER_IRQ (TIMER_IRQ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
        ALUResult = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        @(posedge CLK);
        #1;
        MemWrite  = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] addr, output logic [31:0] data);
        MemWrite  = 1'b0;
        ALUResult = addr;
        #1;
        data = ReadData;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    logic [31:0] rd;
    logic [31:0] c1;
    logic [31:0] c2;
    logic [31:0] acc;

    initial begin
        rst       = 1'b1;
        MemWrite  = 1'b0;
        ALUResult = '0;
        WriteData = '0;
        tick(2);
        rst = 1'b0;

        do_load(32'h08, rd);              chk("reset_ram", rd, 32'h0);
        chk("reset_gpio", {16'h0, GPIO_OUT}, 32'h0);
        chk("reset_irq", {31'h0, TIMER_IRQ}, 32'h0);
        do_load(c_mmio + 32'h04, rd);     chk("reset_cycle", rd, 32'h0);

        do_store(32'h08, 32'hDEADBEEF);
        do_load(32'h08, rd);              chk("ram_load", rd, 32'hDEADBEEF);
        do_load(c_mmio + 32'h08, rd);     chk("store_cnt1", rd, 32'h1);
        do_load(32'h0C, rd);              chk("ram_other", rd, 32'h0);

        // Load during a store to the same word sees the old contents.
        ALUResult = 32'h08;
        WriteData = 32'h1111_1111;
        MemWrite  = 1'b1;
        #1;
        chk("rd_during_wr", ReadData, 32'hDEADBEEF);
        @(posedge CLK);
        #1;
        MemWrite = 1'b0;
        do_load(32'h08, rd);              chk("ram_new", rd, 32'h1111_1111);
        do_load(c_mmio + 32'h08, rd);     chk("store_cnt2", rd, 32'h2);

        do_store(c_mmio, 32'h1234_ABCD);
        chk("gpio_out", {16'h0, GPIO_OUT}, 32'h0000_ABCD);
        do_load(c_mmio, rd);              chk("gpio_rd", rd, 32'h0000_ABCD);

        do_store(32'h06, 32'hFFFF_FFFF);
        do_load(32'h04, rd);              chk("misalign_ram", rd, 32'h0);
        do_load(32'h06, rd);              chk("misalign_ld", rd, 32'h0);
        do_load(c_mmio + 32'h10, rd);     chk("status_err", rd, 32'h2);
        do_load(c_mmio + 32'h08, rd);     chk("store_cnt_ma", rd, 32'h2);
        do_store(c_mmio + 32'h10, 32'h2);
        do_load(c_mmio + 32'h10, rd);     chk("status_clr", rd, 32'h0);

        do_store(32'h0000_1000, 32'h5555_5555);
        do_load(32'h0000_1000, rd);       chk("unmapped_rd", rd, 32'h0);
        do_load(c_mmio + 32'h08, rd);     chk("store_cnt_um", rd, 32'h2);
        do_store(c_mmio + 32'h04, 32'h0);
        do_load(c_mmio + 32'h10, rd);     chk("ro_wr_nofault", rd, 32'h0);
        do_store(c_mmio + 32'h09, 32'h0);
        do_load(c_mmio + 32'h10, rd);     chk("ro_misalign", rd, 32'h2);
        do_store(c_mmio + 32'h10, 32'h2);

`ifdef DMEM_TIMER_EN
        do_store(c_mmio + 32'h0C, 32'd3);
        do_load(c_mmio + 32'h0C, rd);     chk("timer_load", rd, 32'd3);
        chk("irq_e0", {31'h0, TIMER_IRQ}, 32'h0);
        tick(1);                          chk("irq_e1", {31'h0, TIMER_IRQ}, 32'h0);
        tick(1);                          chk("irq_e2", {31'h0, TIMER_IRQ}, 32'h0);
        tick(1);                          chk("irq_e3", {31'h0, TIMER_IRQ}, 32'h1);
        do_load(c_mmio + 32'h10, rd);     chk("status_exp", rd, 32'h1);
        do_store(c_mmio + 32'h0C, 32'd1);
        do_store(c_mmio + 32'h10, 32'h1);
        do_load(c_mmio + 32'h10, rd);     chk("w1c_vs_set", rd, 32'h1);
        do_store(c_mmio + 32'h10, 32'h1);
        do_load(c_mmio + 32'h10, rd);     chk("exp_clr", rd, 32'h0);
        do_store(c_mmio + 32'h0C, 32'd0);
        tick(3);                          chk("timer_zero_noirq", {31'h0, TIMER_IRQ}, 32'h0);
`else
        do_store(c_mmio + 32'h0C, 32'd5);
        tick(10);
        do_load(c_mmio + 32'h0C, rd);     chk("timer_off_rd", rd, 32'h0);
        chk("timer_off_irq", {31'h0, TIMER_IRQ}, 32'h0);
        do_load(c_mmio + 32'h10, rd);     chk("timer_off_stat", rd, 32'h0);
`endif

        do_load(c_mmio + 32'h04, c1);
        tick(10);
        do_load(c_mmio + 32'h04, c2);
        chk("cycle_delta", c2 - c1, 32'd10);

        do_store(32'hFC, 32'hCAFE_F00D);
        // Reset while a store is presented: the store must be dropped.
        rst       = 1'b1;
        ALUResult = 32'h10;
        WriteData = 32'hA5A5_A5A5;
        MemWrite  = 1'b1;
        tick(1);
        rst      = 1'b0;
        MemWrite = 1'b0;
        do_load(c_mmio + 32'h04, rd);     chk("rst_cycle", rd, 32'h0);
        chk("rst_gpio", {16'h0, GPIO_OUT}, 32'h0);
        do_load(c_mmio + 32'h08, rd);     chk("rst_stores", rd, 32'h0);
        acc = '0;
        for (int i = 0; i < 64; i++) begin
            do_load(32'(i * 4), rd);
            acc = acc | rd;
        end
        chk("rst_ram_all", acc, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_data_mem_mmio
`default_nettype wire
